// File: rtl/hls_fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hls_fp_pkg
//  Purpose  : Shared types for the float-multiplier operand-issue stage:
//             data width, issue FSM state encoding and the operand-pair type.
//  Revision : 1.0  initial release
// ============================================================================
package hls_fp_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_pair_t;

endpackage
`default_nettype wire

// File: rtl/hls_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hls_pair_fifo
//  Purpose  : Circular FIFO of operand pairs. The head entry is presented
//             straight from the storage registers, so it is stable until the
//             entry is popped.
//  Ports    : clk, rst       clock / synchronous active-high reset
//             i_push/i_pair  write request and data (ignored when full)
//             i_pop          read request (ignored when empty)
//             o_head         current head pair
//             o_count        occupancy (0..DEPTH)
//             o_full/o_empty occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module hls_pair_fifo
    import hls_fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  fp_pair_t               i_pair,
    input  logic                   i_pop,
    output fp_pair_t               o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]  c_ptr_one  = AW'(1);
    localparam logic [AW:0]    c_cnt_one  = (AW+1)'(1);
    localparam logic [AW:0]    c_cnt_full = (AW+1)'(DEPTH);

    fp_pair_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == c_cnt_full);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_pair;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hls_fmul_issue.sv
`default_nettype none
// ============================================================================
//  Module   : hls_fmul_issue
//  Purpose  : Operand-issue stage in front of the float multiplier FSM.
//             Buffers operand pairs, issues one multiply at a time over
//             req/ack, holds the product in a result register and flags a
//             multiplier that never acknowledges.
//  Ports    : in_valid/in_ready/in_a/in_b     operand input (valid/ready)
//             mul_req/mul_ack/mul_p0/mul_p1/mul_out  multiplier handshake
//             res_valid/res_ready/res_data    product output (valid/ready)
//             count                           FIFO occupancy
//             err                             sticky ack-timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module hls_fmul_issue
    import hls_fp_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FP_W-1:0]        in_a,
    input  logic [FP_W-1:0]        in_b,
    output logic                   mul_req,
    input  logic                   mul_ack,
    output logic [FP_W-1:0]        mul_p0,
    output logic [FP_W-1:0]        mul_p1,
    input  logic [FP_W-1:0]        mul_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [FP_W-1:0]        res_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int            WW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WW-1:0] c_wd_max  = WW'(ACK_TIMEOUT);
    localparam logic [WW-1:0] c_wd_last = WW'(ACK_TIMEOUT - 1);
    localparam logic [WW-1:0] c_wd_one  = WW'(1);

    state_t                   r_state;
    state_t                   w_next_state;
    fp_pair_t                 w_in_pair;
    fp_pair_t                 w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_ack;
    logic                     r_res_valid;
    logic [FP_W-1:0]          r_res_data;
    logic [WW-1:0]            r_wdog;
    logic                     r_err;

    assign w_in_pair = '{a: in_a, b: in_b};
    assign in_ready  = !w_full;
    assign w_push    = in_valid && !w_full;
    // Acks outside REQ are ignored entirely.
    assign w_ack     = (r_state == REQ) && mul_ack;

    hls_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pair  (w_in_pair),
        .i_pop   (w_ack),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign mul_p0    = w_head.a;
    assign mul_p1    = w_head.b;
    assign mul_req   = (r_state == REQ);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Issue only when the result register is free or being drained this
    // cycle; an ack can then never collide with an undrained result.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty && (!r_res_valid || res_ready)) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (mul_ack) begin
                    w_next_state = GAP;
                end
            end
            // One low cycle lets the multiplier rearm before the next req.
            GAP:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_ack) begin
            r_res_valid <= 1'b1;
            r_res_data  <= mul_out;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Watchdog saturates at the limit; the request itself keeps waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else if ((r_state == REQ) && !mul_ack) begin
            if (r_wdog != c_wd_max) begin
                r_wdog <= r_wdog + c_wd_one;
            end
            if (r_wdog == c_wd_last) begin
                r_err <= 1'b1;
            end
        end else begin
            r_wdog <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hls_fmul_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hls_fmul_issue
//  Purpose  : Directed self-checking bench for hls_fmul_issue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hls_fmul_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mul_req;
    logic        mul_ack;
    logic [31:0] mul_p0;
    logic [31:0] mul_p1;
    logic [31:0] mul_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  count;
    logic        err;

    int n_checks;
    int n_errors;

    logic [31:0] c_a [5];
    logic [31:0] c_b [5];
    logic [31:0] c_p [5];

    hls_fmul_issue #(
        .DEPTH       (4),
        .ACK_TIMEOUT (15)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_req   (mul_req),
        .mul_ack   (mul_ack),
        .mul_p0    (mul_p0),
        .mul_p1    (mul_p1),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mul_req && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'd0, mul_req}, 32'd1);
    endtask

    // Ack the current request with a product, then accept the result.
    task automatic ack_and_take(input string tag, input logic [31:0] prod);
        mul_ack = 1'b1;
        mul_out = prod;
        step();
        mul_ack = 1'b0;
        mul_out = 32'h0;
        chk({tag, "_gap_req"}, {31'd0, mul_req}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_rdata"}, res_data, prod);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        mul_ack   = 1'b0;
        mul_out   = '0;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_a[i] = 32'h3F80_0000 + i;
            c_b[i] = 32'h4000_0000 + (i << 4);
            c_p[i] = 32'hC0A0_0000 | i;
        end

        // ---------------- reset values ----------------
        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mul_req", {31'd0, mul_req}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_p0", mul_p0, 32'd0);

        // ---------------- 1: single multiply, latency ----------------
        in_valid = 1'b1;
        in_a     = 32'h3F80_0000;
        in_b     = 32'h4000_0000;
        step();                               // push edge ends cycle t
        in_valid = 1'b0;
        chk("t1_req_t1", {31'd0, mul_req}, 32'd0);
        chk("t1_count", {29'd0, count}, 32'd1);
        step();                               // cycle t+2
        chk("t1_req_t2", {31'd0, mul_req}, 32'd1);
        chk("t1_p0", mul_p0, 32'h3F80_0000);
        chk("t1_p1", mul_p1, 32'h4000_0000);
        step();
        step();
        chk("t1_req_hold", {31'd0, mul_req}, 32'd1);
        step();                               // ack 3 cycles after req
        ack_and_take("t1", 32'h4000_0000);
        chk("t1_rvalid_clr", {31'd0, res_valid}, 32'd0);
        chk("t1_count_end", {29'd0, count}, 32'd0);

        // ---------------- 2: fill FIFO, backpressure ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = c_a[i];
            in_b     = c_b[i];
            step();
        end
        chk("t2_count_full", {29'd0, count}, 32'd4);
        chk("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("t2_req", {31'd0, mul_req}, 32'd1);
        in_a = c_a[4];
        in_b = c_b[4];
        step();
        step();
        chk("t2_count_hold", {29'd0, count}, 32'd4);
        chk("t2_in_ready_hold", {31'd0, in_ready}, 32'd0);
        chk("t2_p0_head", mul_p0, c_a[0]);
        mul_ack = 1'b1;
        mul_out = c_p[0];
        step();
        mul_ack = 1'b0;
        chk("t2_in_ready_pop", {31'd0, in_ready}, 32'd1);
        chk("t2_count_pop", {29'd0, count}, 32'd3);
        step();                               // fifth pair accepted here
        in_valid = 1'b0;
        chk("t2_count_refill", {29'd0, count}, 32'd4);
        chk("t2_rvalid", {31'd0, res_valid}, 32'd1);
        chk("t2_rdata", res_data, c_p[0]);

        // ---------------- 3: result backpressure blocks issue ----------------
        step();
        step();
        step();
        chk("t3_no_req", {31'd0, mul_req}, 32'd0);
        chk("t3_rvalid_held", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("t3_req_next", {31'd0, mul_req}, 32'd1);
        chk("t3_rvalid_clr", {31'd0, res_valid}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            wait_req($sformatf("t3_req%0d", i));
            chk($sformatf("t3_p0_%0d", i), mul_p0, c_a[i]);
            chk($sformatf("t3_p1_%0d", i), mul_p1, c_b[i]);
            ack_and_take($sformatf("t3_r%0d", i), c_p[i]);
        end
        chk("t3_count_end", {29'd0, count}, 32'd0);

        // ---------------- 4: simultaneous push/pop at count=2 ----------------
        do_reset();
        in_valid = 1'b1;
        in_a     = c_a[0];
        in_b     = c_b[0];
        step();
        in_a     = c_a[1];
        in_b     = c_b[1];
        step();
        chk("t4_count2", {29'd0, count}, 32'd2);
        chk("t4_req", {31'd0, mul_req}, 32'd1);
        in_a     = c_a[2];
        in_b     = c_b[2];
        mul_ack  = 1'b1;
        mul_out  = c_p[0];
        step();
        in_valid = 1'b0;
        mul_ack  = 1'b0;
        chk("t4_count_same", {29'd0, count}, 32'd2);
        chk("t4_rdata0", res_data, c_p[0]);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        for (int i = 1; i < 3; i++) begin
            wait_req($sformatf("t4_req%0d", i));
            chk($sformatf("t4_p0_%0d", i), mul_p0, c_a[i]);
            ack_and_take($sformatf("t4_r%0d", i), c_p[i]);
        end

        // ---------------- 5: ack timeout ----------------
        do_reset();
        in_valid = 1'b1;
        in_a     = c_a[3];
        in_b     = c_b[3];
        step();
        in_valid = 1'b0;
        wait_req("t5_req");                   // first req cycle c
        for (int k = 0; k < 14; k++) begin
            step();
        end
        chk("t5_err_before", {31'd0, err}, 32'd0);
        step();                               // after 15 req cycles
        chk("t5_err_set", {31'd0, err}, 32'd1);
        chk("t5_req_still", {31'd0, mul_req}, 32'd1);
        chk("t5_p0", mul_p0, c_a[3]);
        chk("t5_p1", mul_p1, c_b[3]);
        step();
        step();
        chk("t5_err_sticky", {31'd0, err}, 32'd1);

        // ---------------- 6: reset while in REQ ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_req", {31'd0, mul_req}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_rvalid", {31'd0, res_valid}, 32'd0);
        chk("t6_err", {31'd0, err}, 32'd0);
        mul_ack = 1'b1;
        mul_out = 32'hDEAD_BEEF;
        step();
        mul_ack = 1'b0;
        step();
        chk("t6_stray_rvalid", {31'd0, res_valid}, 32'd0);
        chk("t6_stray_rdata", res_data, 32'd0);
        chk("t6_stray_req", {31'd0, mul_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
